// File: rtl/norm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : norm_pkg                                                     |
// | Description : Shared constants, FSM encoding and saturation helper for the |
// |               block normalization divider.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package norm_pkg;

    localparam int N          = 9;
    localparam int CW         = 8;
    localparam int MW         = 16;
    localparam int FRAC       = 8;
    localparam int QW         = FRAC + 1;
    localparam int DIV_CYCLES = CW + FRAC;
    localparam int IDX_W      = 4;
    localparam int CNT_W      = $clog2(DIV_CYCLES);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [QW-1:0]    Q_ONE    = {1'b1, {FRAC{1'b0}}};

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_DIV  = 2'd2;
    localparam state_t ST_EMIT = 2'd3;

    // Quotients above 1.0 can only come from truncated magnitudes upstream;
    // they clamp to exactly 1.0. A zero divisor yields an all-ones quotient,
    // which is forced to zero instead.
    function automatic logic [QW-1:0] sat_quotient(
        input logic [DIV_CYCLES-1:0] q,
        input logic                  zero_div
    );
        logic [QW-1:0] res;
        if (zero_div) begin
            res = '0;
        end else if (q > {{(DIV_CYCLES-QW){1'b0}}, Q_ONE}) begin
            res = Q_ONE;
        end else begin
            res = q[QW-1:0];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/norm_seq_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : norm_seq_div                                                 |
// | Description : Restoring unsigned divider, one quotient bit per clock,      |
// |               MSB first, restarted by a load strobe.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module norm_seq_div
    import norm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DIV_CYCLES-1:0] dividend,
    input  logic [MW-1:0]         divisor,
    output logic [DIV_CYCLES-1:0] quotient,
    output logic                  last_step,
    output logic                  q_ready
);

    localparam logic [CNT_W-1:0] c_CNT_START = CNT_W'(DIV_CYCLES - 1);

    logic [DIV_CYCLES-1:0] r_dvd;
    logic [MW-1:0]         r_rem;
    logic [DIV_CYCLES-1:0] r_quo;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_run;
    logic                  r_ready;

    logic [MW:0]           w_trial;
    logic                  w_ge;
    logic [MW-1:0]         w_diff;

    // The MW+1-bit partial remainder exists only as the trial value; once
    // reduced it is always below the divisor and fits back into MW bits.
    assign w_trial = {r_rem, r_dvd[DIV_CYCLES-1]};
    assign w_ge    = (w_trial >= {1'b0, divisor});
    assign w_diff  = w_trial[MW-1:0] - divisor;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_ready <= 1'b0;
        end else if (load) begin
            r_dvd   <= dividend;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= c_CNT_START;
            r_run   <= 1'b1;
            r_ready <= 1'b0;
        end else if (r_run) begin
            r_dvd <= {r_dvd[DIV_CYCLES-2:0], 1'b0};
            r_rem <= w_ge ? w_diff : w_trial[MW-1:0];
            r_quo <= {r_quo[DIV_CYCLES-2:0], w_ge};
            if (r_cnt == '0) begin
                r_run   <= 1'b0;
                r_ready <= 1'b1;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign quotient  = r_quo;
    assign last_step = r_run && (r_cnt == '0);
    assign q_ready   = r_ready;

endmodule
`default_nettype wire

// File: rtl/norm_divide.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : norm_divide                                                  |
// | Description : Divides the 9 block components by the root magnitude and    |
// |               streams unsigned Q1.FRAC results, one per strobe.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module norm_divide
    import norm_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N*CW-1:0]     comp_flat,
    input  logic [MW-1:0]       magnitude,
    output logic                busy,
    output logic                out_valid,
    output logic [IDX_W-1:0]    out_idx,
    output logic [QW-1:0]       out_q,
    output logic                done
);

    state_t                r_state;
    logic [CW-1:0]         r_comp [N];
    logic [MW-1:0]         r_mag;
    logic [IDX_W-1:0]      r_k;
    logic [IDX_W-1:0]      r_out_idx;
    logic [QW-1:0]         r_out_q;

    logic                  w_div_load;
    logic [DIV_CYCLES-1:0] w_dividend;
    logic [DIV_CYCLES-1:0] w_quo;
    logic                  w_last_step;
    logic                  w_q_ready;
    logic [QW-1:0]         w_q_final;
    logic                  w_emit;

    assign w_div_load = (r_state == ST_LOAD);
    assign w_dividend = {r_comp[r_k], {FRAC{1'b0}}};

    norm_seq_div u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (w_div_load),
        .dividend  (w_dividend),
        .divisor   (r_mag),
        .quotient  (w_quo),
        .last_step (w_last_step),
        .q_ready   (w_q_ready)
    );

    assign w_q_final = sat_quotient(w_quo, (r_mag == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_mag     <= '0;
            r_k       <= '0;
            r_out_idx <= '0;
            r_out_q   <= '0;
            for (int i = 0; i < N; i++) begin
                r_comp[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            r_comp[i] <= comp_flat[i*CW +: CW];
                        end
                        r_mag   <= magnitude;
                        r_k     <= '0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_DIV;
                end
                ST_DIV: begin
                    if (w_last_step) begin
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    r_out_idx <= r_k;
                    r_out_q   <= w_q_final;
                    if (r_k == LAST_IDX) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_k     <= r_k + 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // During EMIT the fresh quotient is presented directly; the held copies
    // keep the outputs stable between strobes.
    assign w_emit    = (r_state == ST_EMIT) && w_q_ready;
    assign out_valid = w_emit;
    assign done      = w_emit && (r_k == LAST_IDX);
    assign busy      = (r_state != ST_IDLE);
    assign out_idx   = w_emit ? r_k : r_out_idx;
    assign out_q     = w_emit ? w_q_final : r_out_q;

endmodule
`default_nettype wire

// File: tb/tb_norm_divide.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_norm_divide                                               |
// | Description : Directed self-checking bench for norm_divide.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_norm_divide;
    import norm_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [N*CW-1:0]     comp_flat;
    logic [MW-1:0]       magnitude;
    logic                busy;
    logic                out_valid;
    logic [IDX_W-1:0]    out_idx;
    logic [QW-1:0]       out_q;
    logic                done;

    int                  n_checks = 0;
    int                  n_errors = 0;

    logic [CW-1:0]       cv [N];
    logic [QW-1:0]       eq [N];
    logic [QW-1:0]       last_q;
    logic [IDX_W-1:0]    last_idx;

    norm_divide dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .comp_flat (comp_flat),
        .magnitude (magnitude),
        .busy      (busy),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_q     (out_q),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start a job from the current cycle and check every cycle up to the one
    // where busy must have dropped. Optional stray start / reset injection.
    task automatic run_job(input string name, input logic [MW-1:0] mag,
                           input int inj_cyc, input int rst_cyc);
        bit aborted;
        bit exp_valid;
        int exp_k;
        aborted = 1'b0;
        for (int i = 0; i < N; i++) comp_flat[i*CW +: CW] = cv[i];
        magnitude = mag;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 162; cyc++) begin
            @(posedge clk);
            #1;
            if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
                rst      = 1'b0;
                aborted  = 1'b1;
                last_q   = '0;
                last_idx = '0;
            end
            exp_valid = !aborted && cyc >= 17 && ((cyc - 17) % 18 == 0);
            exp_k     = (cyc >= 17) ? (cyc - 17) / 18 : 0;
            check($sformatf("%s valid@%0d", name, cyc), 32'(out_valid), 32'(exp_valid));
            check($sformatf("%s done@%0d", name, cyc), 32'(done),
                  32'(exp_valid && exp_k == N - 1));
            check($sformatf("%s busy@%0d", name, cyc), 32'(busy),
                  32'(!aborted && cyc <= 161));
            if (exp_valid) begin
                check($sformatf("%s idx@%0d", name, cyc), 32'(out_idx), 32'(exp_k));
                check($sformatf("%s q%0d", name, exp_k), 32'(out_q), 32'(eq[exp_k]));
                last_q   = eq[exp_k];
                last_idx = IDX_W'(exp_k);
            end else begin
                check($sformatf("%s holdq@%0d", name, cyc), 32'(out_q), 32'(last_q));
                check($sformatf("%s holdidx@%0d", name, cyc), 32'(out_idx), 32'(last_idx));
            end
            if (cyc == inj_cyc) begin
                start     = 1'b1;
                comp_flat = '1;
                magnitude = 16'd1;
            end
            if (cyc == inj_cyc + 1) start = 1'b0;
            if (cyc == rst_cyc) rst = 1'b1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        comp_flat = '0;
        magnitude = '0;
        last_q    = '0;
        last_idx  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset valid", 32'(out_valid), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset idx", 32'(out_idx), 32'd0);
        check("reset q", 32'(out_q), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        cv = '{8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        eq = '{9'd153, 9'd204, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0};
        run_job("j34", 16'd5, 0, 0);

        // Stray start with different operands at E+40 must be ignored.
        cv = '{default: 8'd10};
        eq = '{default: 9'd85};
        run_job("j10", 16'd30, 40, 0);

        // Back-to-back: each of these begins in the cycle after busy drops.
        cv = '{8'd200, 8'd100, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        eq = '{9'd256, 9'd128, 9'd64, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0};
        run_job("jeq", 16'd200, 0, 0);

        cv = '{8'd255, 8'd201, 8'd199, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        eq = '{9'd256, 9'd256, 9'd254, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0};
        run_job("jsat", 16'd200, 0, 0);

        cv = '{default: 8'd7};
        eq = '{default: 9'd0};
        run_job("jzero", 16'd0, 0, 0);

        // Reset asserted mid-job at E+50; no further strobes may appear.
        cv = '{default: 8'd10};
        eq = '{default: 9'd85};
        run_job("jrst", 16'd30, 0, 50);

        cv = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        eq = '{9'd28, 9'd56, 9'd85, 9'd113, 9'd142, 9'd170, 9'd199, 9'd227, 9'd256};
        run_job("jramp", 16'd9, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
